mem_stage_lsu: RTL and testbench

Parametrised memory-stage load/store unit, the successor to the current word-only MEM stage. It issues sub-word and full-word loads and stores (byte/half/word, plus double when `N=64`) over the existing `proc_req`/`mem_ready`/`valid` memory handshake, generating byte enables. Load data is aligned and sign/zero-extended before it is registered into the MEM/WB pipeline registers. It sits between EX/MEM and WB and stalls the pipeline through `stallMem` while an access is outstanding.

---
 rtl/mem_stage_lsu_if.sv | 17 +
 rtl/mem_stage_lsu.sv | 178 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - request/response bus between the MEM-stage LSU and data memory
interface mem_stage_lsu_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 32
);
    logic              proc_req;
    logic              we_out;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      wdata;
    logic [N/8-1:0]    be;
    logic              mem_ready;
    logic              valid;
    logic [N-1:0]      rdata;

    modport master (output proc_req, we_out, addr, wdata, be, input mem_ready, valid, rdata);
    modport slave  (input proc_req, we_out, addr, wdata, be, output mem_ready, valid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with byte enables and load extension
// Optional MISALIGN_TRAP_EN: misaligned ops trap instead of being forced aligned.
module mem_stage_lsu #(
    parameter int N      = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_en,
    input  logic              mem_op,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] ALUres,
    input  logic [N-1:0]      wrData_in,
    input  logic [4:0]        Rdest_in,
    input  logic [2:0]        cwWB_in,
    mem_stage_lsu_if.master   mem,
    output logic [N-1:0]      loadData,
    output logic [ADDR_W-1:0] ALUout,
    output logic [4:0]        Rdest_out,
    output logic [2:0]        cwWB,
    output logic              misalign,
    output logic              stallMem
);
    localparam int NB   = N / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state_q, state_d;

    logic [1:0]        size_d, size_q;
    logic [OFFW-1:0]   off_raw, off_d, off_q;
    logic [NB-1:0]     be_d, be_q;
    logic [N-1:0]      wdata_d, wdata_q;
    logic [ADDR_W-1:0] addr_q, alu_q;
    logic              we_q, uns_q, trap_d, trap_q;
    logic [4:0]        rd_q;
    logic [2:0]        cw_q;
    logic [N-1:0]      ld_q, shifted, keep, fmt;
    logic              sbit;
    logic [N-1:0]      loadData_q;
    logic [ADDR_W-1:0] ALUout_q;
    logic [4:0]        Rdest_q;
    logic [2:0]        cwWB_q;
    logic              capture_en, ld_en, wb_en;

    // Incoming op decode; the offset is masked to the access size so a
    // misaligned op either traps or silently becomes the aligned access.
    always_comb begin
        size_d = funct3[1:0];
        if (N == 32 && funct3[1:0] == 2'd3) size_d = 2'd2;
        off_raw = ALUres[OFFW-1:0];
        off_d   = off_raw & ~OFFW'((4'd1 << size_d) - 4'd1);
        case (size_d)
            2'd0:    be_d = NB'(1);
            2'd1:    be_d = NB'(3);
            2'd2:    be_d = NB'(15);
            default: be_d = {NB{1'b1}};
        endcase
        be_d = be_d << off_d;
        case (size_d)
            2'd0:    wdata_d = {NB{wrData_in[7:0]}};
            2'd1:    wdata_d = {(N/16){wrData_in[15:0]}};
            2'd2:    wdata_d = {(N/32){wrData_in[31:0]}};
            default: wdata_d = wrData_in;
        endcase
    end

    always_comb begin
        shifted = mem.rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    begin keep = N'(8'hFF);          sbit = shifted[7];   end
            2'd1:    begin keep = N'(16'hFFFF);       sbit = shifted[15];  end
            2'd2:    begin keep = N'(32'hFFFF_FFFF);  sbit = shifted[31];  end
            default: begin keep = '1;                 sbit = shifted[N-1]; end
        endcase
        fmt = shifted & keep;
        if (sbit && !uns_q) fmt = fmt | ~keep;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_op) state_d = trap_d ? DONE : REQ;
            REQ:     if (mem.mem_ready) state_d = (we_q || mem.valid) ? DONE : WAIT;
            WAIT:    if (mem.valid) state_d = DONE;
            DONE:    if (pipe_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // stallMem is gated by reset so every output reads 0 while rst is low.
    always_comb begin
        mem.proc_req = (state_q == REQ);
        mem.we_out   = (state_q == REQ) && we_q;
        mem.addr     = addr_q;
        mem.wdata    = wdata_q;
        mem.be       = be_q;
        stallMem     = rst && ((state_q == REQ) || (state_q == WAIT) || (state_q == IDLE && mem_op));
        capture_en   = (state_q == IDLE) && mem_op;
        ld_en        = ((state_q == REQ) && mem.mem_ready && !we_q && mem.valid)
                     || ((state_q == WAIT) && mem.valid);
        wb_en        = pipe_en && (((state_q == IDLE) && !mem_op) || (state_q == DONE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            trap_q     <= 1'b0;
            rd_q       <= '0;
            cw_q       <= '0;
            alu_q      <= '0;
            ld_q       <= '0;
            loadData_q <= '0;
            ALUout_q   <= '0;
            Rdest_q    <= '0;
            cwWB_q     <= '0;
        end else begin
            if (capture_en) begin
                addr_q  <= {ALUres[ADDR_W-1:OFFW], OFFW'(0)};
                wdata_q <= wdata_d;
                be_q    <= be_d;
                we_q    <= mem_we;
                off_q   <= off_d;
                size_q  <= size_d;
                uns_q   <= funct3[2];
                trap_q  <= trap_d;
                rd_q    <= Rdest_in;
                cw_q    <= cwWB_in;
                alu_q   <= ALUres;
                ld_q    <= '0;
            end
            if (ld_en) ld_q <= fmt;
            if (wb_en) begin
                if (state_q == DONE) begin
                    loadData_q <= ld_q;
                    ALUout_q   <= alu_q;
                    Rdest_q    <= rd_q;
                    cwWB_q     <= trap_q ? 3'b000 : cw_q;
                end else begin
                    loadData_q <= '0;
                    ALUout_q   <= ALUres;
                    Rdest_q    <= Rdest_in;
                    cwWB_q     <= cwWB_in;
                end
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap_d = (off_raw != off_d);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       misalign_q <= 1'b0;
        else if (wb_en) misalign_q <= (state_q == DONE) && trap_q;
    end
    assign misalign = misalign_q;
`else
    assign trap_d   = 1'b0;
    assign misalign = 1'b0;
`endif

    assign loadData  = loadData_q;
    assign ALUout    = ALUout_q;
    assign Rdest_out = Rdest_q;
    assign cwWB      = cwWB_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu at N=32 and N=64
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_en, mem_op, mem_op64, mem_we;
    logic [2:0]  funct3;
    logic [31:0] ALUres;
    logic [31:0] wrData_in;
    logic [63:0] wrData64;
    logic [4:0]  Rdest_in;
    logic [2:0]  cwWB_in;
    logic [31:0] loadData, ALUout;
    logic [4:0]  Rdest_out;
    logic [2:0]  cwWB;
    logic        misalign, stallMem;
    logic [63:0] loadData64;
    logic [31:0] ALUout64;
    logic [4:0]  Rdest64;
    logic [2:0]  cwWB64;
    logic        misalign64, stall64;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mem_stage_lsu_if #(.N(32), .ADDR_W(32)) m32 ();
    mem_stage_lsu_if #(.N(64), .ADDR_W(32)) m64 ();

    mem_stage_lsu #(.N(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .mem_op(mem_op), .mem_we(mem_we),
        .funct3(funct3), .ALUres(ALUres), .wrData_in(wrData_in), .Rdest_in(Rdest_in),
        .cwWB_in(cwWB_in), .mem(m32), .loadData(loadData), .ALUout(ALUout),
        .Rdest_out(Rdest_out), .cwWB(cwWB), .misalign(misalign), .stallMem(stallMem));

    mem_stage_lsu #(.N(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .mem_op(mem_op64), .mem_we(mem_we),
        .funct3(funct3), .ALUres(ALUres), .wrData_in(wrData64), .Rdest_in(Rdest_in),
        .cwWB_in(cwWB_in), .mem(m64), .loadData(loadData64), .ALUout(ALUout64),
        .Rdest_out(Rdest64), .cwWB(cwWB64), .misalign(misalign64), .stallMem(stall64));

    task automatic idle_all();
        mem_op = 0; mem_op64 = 0; mem_we = 0; funct3 = 0; ALUres = 0; pipe_en = 1;
        wrData_in = 0; wrData64 = 0; Rdest_in = 0; cwWB_in = 0;
        m32.mem_ready = 0; m32.valid = 0; m32.rdata = 0;
        m64.mem_ready = 0; m64.valid = 0; m64.rdata = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_all();
        #1;
        total++; if (m32.proc_req !== 1'b0 || m32.be !== 4'h0 || m32.addr !== 32'h0) begin
            bad++; $display("FAIL reset_bus: got req=%b be=%h addr=%h exp 0/0/0", m32.proc_req, m32.be, m32.addr); end
        total++; if (loadData !== 32'h0 || cwWB !== 3'h0 || misalign !== 1'b0 || stallMem !== 1'b0) begin
            bad++; $display("FAIL reset_wb: got ld=%h cw=%h mis=%b stall=%b exp 0", loadData, cwWB, misalign, stallMem); end
        mem_op = 1;
        #1;
        total++; if (stallMem !== 1'b0) begin
            bad++; $display("FAIL reset_stall_gate: got %b exp 0", stallMem); end
        mem_op = 0;
        @(negedge clk); @(negedge clk);
        rst = 1;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        ALUres = 32'h55; Rdest_in = 5'd3; cwWB_in = 3'd6; pipe_en = 1;
        m32.valid = 1; m32.rdata = 32'hFFFF_FFFF;
        #1;
        total++; if (stallMem !== 1'b0 || m32.proc_req !== 1'b0) begin
            bad++; $display("FAIL pass_stall: got stall=%b req=%b exp 0/0", stallMem, m32.proc_req); end
        @(negedge clk);
        pipe_en = 0; ALUres = 32'h77; m32.valid = 0;
        #1;
        total++; if (ALUout !== 32'h55 || Rdest_out !== 5'd3 || cwWB !== 3'd6 || loadData !== 32'h0) begin
            bad++; $display("FAIL pass_load: got alu=%h rd=%0d cw=%0d ld=%h exp 55/3/6/0", ALUout, Rdest_out, cwWB, loadData); end
        @(negedge clk);
        #1;
        total++; if (ALUout !== 32'h55) begin
            bad++; $display("FAIL pass_hold: got %h exp 55", ALUout); end
        pipe_en = 1;
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int stalls = 0;
        int reqs = 0;
        @(negedge clk);
        mem_op = 1; mem_we = 1; funct3 = f3; ALUres = a; wrData_in = d;
        Rdest_in = 5'd5; cwWB_in = 3'b100; pipe_en = 1; m32.mem_ready = 1;
        #1 stalls += int'(stallMem);
        reqs += int'(m32.proc_req);
        @(negedge clk);
        #1;
        total++; if (m32.addr !== exp_addr || m32.be !== exp_be || m32.we_out !== 1'b1) begin
            bad++; $display("FAIL %s_req: got addr=%h be=%h we=%b exp %h/%h/1", name, m32.addr, m32.be, m32.we_out, exp_addr, exp_be); end
        total++; if (m32.wdata !== exp_wd) begin
            bad++; $display("FAIL %s_wdata: got %h exp %h", name, m32.wdata, exp_wd); end
        stalls += int'(stallMem);
        reqs += int'(m32.proc_req);
        @(negedge clk);
        #1 stalls += int'(stallMem);
        reqs += int'(m32.proc_req);
        total++; if (stalls != 2 || reqs != 1) begin
            bad++; $display("FAIL %s_occupancy: got stalls=%0d reqs=%0d exp 2/1", name, stalls, reqs); end
        @(negedge clk);
        mem_op = 0; mem_we = 0; m32.mem_ready = 0;
        #1;
        total++; if (ALUout !== a || Rdest_out !== 5'd5 || cwWB !== 3'b100 || loadData !== 32'h0) begin
            bad++; $display("FAIL %s_wb: got alu=%h rd=%0d cw=%0d ld=%h exp %h/5/4/0", name, ALUout, Rdest_out, cwWB, loadData, a); end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] rd, input int w, input logic [31:0] exp);
        int stalls = 0;
        @(negedge clk);
        mem_op = 1; mem_we = 0; funct3 = f3; ALUres = a; Rdest_in = 5'd7; cwWB_in = 3'b101;
        pipe_en = 1; m32.mem_ready = 0; m32.valid = 0; m32.rdata = 0;
        #1 stalls += int'(stallMem);
        @(negedge clk);
        m32.mem_ready = 1; m32.valid = (w == 0); m32.rdata = (w == 0) ? rd : 32'h0;
        #1;
        total++; if (m32.proc_req !== 1'b1 || m32.we_out !== 1'b0 || m32.addr !== exp_addr) begin
            bad++; $display("FAIL %s_req: got req=%b we=%b addr=%h exp 1/0/%h", name, m32.proc_req, m32.we_out, m32.addr, exp_addr); end
        total++; if (m32.be !== exp_be) begin
            bad++; $display("FAIL %s_be: got %h exp %h", name, m32.be, exp_be); end
        stalls += int'(stallMem);
        for (int i = 1; i <= w; i++) begin
            @(negedge clk);
            m32.mem_ready = 0; m32.valid = (i == w); m32.rdata = (i == w) ? rd : 32'h0;
            #1;
            total++; if (m32.proc_req !== 1'b0) begin
                bad++; $display("FAIL %s_wait_req: got %b exp 0", name, m32.proc_req); end
            stalls += int'(stallMem);
        end
        @(negedge clk);
        m32.mem_ready = 0; m32.valid = 0; m32.rdata = 0;
        #1 stalls += int'(stallMem);
        total++; if (stalls != 2 + w) begin
            bad++; $display("FAIL %s_stall: got %0d exp %0d", name, stalls, 2 + w); end
        @(negedge clk);
        mem_op = 0;
        #1;
        total++; if (loadData !== exp) begin
            bad++; $display("FAIL %s_data: got %h exp %h", name, loadData, exp); end
        total++; if (ALUout !== a || Rdest_out !== 5'd7 || cwWB !== 3'b101) begin
            bad++; $display("FAIL %s_wb: got alu=%h rd=%0d cw=%0d exp %h/7/5", name, ALUout, Rdest_out, cwWB, a); end
    endtask

    task automatic test_done_hold();
        int reqs = 0;
        int stalls = 0;
        @(negedge clk);
        mem_op = 0; pipe_en = 1;
        @(negedge clk);
        mem_op = 1; mem_we = 0; funct3 = 3'b010; ALUres = 32'h104;
        #1 reqs += int'(m32.proc_req);
        @(negedge clk);
        m32.mem_ready = 1; m32.valid = 1; m32.rdata = 32'h1122_3344;
        #1 reqs += int'(m32.proc_req);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pipe_en = 0; m32.rdata = 32'hFFFF_FFFF;
            #1 reqs += int'(m32.proc_req);
            stalls += int'(stallMem);
        end
        total++; if (loadData !== 32'h0) begin
            bad++; $display("FAIL hold_no_load: got %h exp 0", loadData); end
        @(negedge clk);
        pipe_en = 1; m32.mem_ready = 0; m32.valid = 0; m32.rdata = 0;
        #1 reqs += int'(m32.proc_req);
        stalls += int'(stallMem);
        @(negedge clk);
        mem_op = 0;
        #1;
        total++; if (loadData !== 32'h1122_3344) begin
            bad++; $display("FAIL hold_data: got %h exp 11223344", loadData); end
        total++; if (reqs != 1 || stalls != 0) begin
            bad++; $display("FAIL hold_req_count: got reqs=%0d stalls=%0d exp 1/0", reqs, stalls); end
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        int reqs = 0;
        @(negedge clk);
        mem_op = 1; mem_we = 0; funct3 = 3'b010; ALUres = 32'h101; Rdest_in = 5'd9; cwWB_in = 3'b111;
        #1 reqs += int'(m32.proc_req);
        @(negedge clk);
        m32.mem_ready = 1;
        #1 reqs += int'(m32.proc_req);
        total++; if (stallMem !== 1'b0) begin
            bad++; $display("FAIL trap_stall: got %b exp 0", stallMem); end
        @(negedge clk);
        mem_op = 0; m32.mem_ready = 0;
        #1 reqs += int'(m32.proc_req);
        total++; if (misalign !== 1'b1 || cwWB !== 3'b000 || Rdest_out !== 5'd9) begin
            bad++; $display("FAIL trap_wb: got mis=%b cw=%0d rd=%0d exp 1/0/9", misalign, cwWB, Rdest_out); end
        total++; if (reqs != 0) begin
            bad++; $display("FAIL trap_no_req: got %0d exp 0", reqs); end
        @(negedge clk);
        #1;
        total++; if (misalign !== 1'b0) begin
            bad++; $display("FAIL trap_clear: got %b exp 0", misalign); end
`else
        test_load("lw_mis", 3'b010, 32'h101, 32'h100, 4'hF, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
        total++; if (misalign !== 1'b0) begin
            bad++; $display("FAIL mis_flag: got %b exp 0", misalign); end
`endif
    endtask

    task automatic test_n64();
        @(negedge clk);
        mem_op64 = 1; mem_we = 1; funct3 = 3'b011; ALUres = 32'h108;
        wrData64 = 64'h0123_4567_89AB_CDEF; m64.mem_ready = 1;
        #1;
        total++; if (stall64 !== 1'b1) begin
            bad++; $display("FAIL sd_stall: got %b exp 1", stall64); end
        @(negedge clk);
        #1;
        total++; if (m64.proc_req !== 1'b1 || m64.be !== 8'hFF || m64.addr !== 32'h108) begin
            bad++; $display("FAIL sd_req: got req=%b be=%h addr=%h exp 1/ff/108", m64.proc_req, m64.be, m64.addr); end
        total++; if (m64.wdata !== 64'h0123_4567_89AB_CDEF) begin
            bad++; $display("FAIL sd_wdata: got %h exp 0123456789abcdef", m64.wdata); end
        @(negedge clk);
        @(negedge clk);
        mem_op64 = 1; mem_we = 0; funct3 = 3'b010; ALUres = 32'h114; m64.mem_ready = 0;
        @(negedge clk);
        m64.mem_ready = 1; m64.valid = 1; m64.rdata = 64'h8000_0001_0000_0000;
        #1;
        total++; if (m64.be !== 8'hF0 || m64.addr !== 32'h110) begin
            bad++; $display("FAIL lw64_req: got be=%h addr=%h exp f0/110", m64.be, m64.addr); end
        @(negedge clk);
        m64.mem_ready = 0; m64.valid = 0;
        @(negedge clk);
        mem_op64 = 0;
        #1;
        total++; if (loadData64 !== 64'hFFFF_FFFF_8000_0001) begin
            bad++; $display("FAIL lw64_data: got %h exp ffffffff80000001", loadData64); end
        @(negedge clk);
        mem_op64 = 1; funct3 = 3'b011; ALUres = 32'h110; Rdest_in = 5'd4; cwWB_in = 3'd1;
        @(negedge clk);
        m64.mem_ready = 1; m64.valid = 0;
        @(negedge clk);
        m64.mem_ready = 0;
        #1;
        total++; if (m64.proc_req !== 1'b0 || stall64 !== 1'b1) begin
            bad++; $display("FAIL ld64_wait: got req=%b stall=%b exp 0/1", m64.proc_req, stall64); end
        #1 rst = 0;
        #1;
        total++; if (m64.proc_req !== 1'b0 || stall64 !== 1'b0 || m64.be !== 8'h0 || m64.addr !== 32'h0) begin
            bad++; $display("FAIL rst64_bus: got req=%b stall=%b be=%h addr=%h exp 0", m64.proc_req, stall64, m64.be, m64.addr); end
        total++; if (loadData64 !== 64'h0 || ALUout64 !== 32'h0 || cwWB64 !== 3'h0 || misalign64 !== 1'b0) begin
            bad++; $display("FAIL rst64_wb: got ld=%h alu=%h cw=%0d mis=%b exp 0", loadData64, ALUout64, cwWB64, misalign64); end
        @(negedge clk);
        rst = 1; mem_op64 = 0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store("sw", 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h100, 4'hF, 32'hDEAD_BEEF);
        test_store("sh", 3'b001, 32'h102, 32'h0000_1234, 32'h100, 4'hC, 32'h1234_1234);
        test_store("sb", 3'b000, 32'h101, 32'h0000_00A5, 32'h100, 4'h2, 32'hA5A5_A5A5);
        test_load("lb", 3'b000, 32'h103, 32'h100, 4'h8, 32'h80FF_0000, 2, 32'hFFFF_FF80);
        test_load("lbu", 3'b100, 32'h103, 32'h100, 4'h8, 32'h80FF_0000, 2, 32'h0000_0080);
        test_load("lh", 3'b001, 32'h102, 32'h100, 4'hC, 32'h8001_ABCD, 0, 32'hFFFF_8001);
        test_load("lhu", 3'b101, 32'h100, 32'h100, 4'h3, 32'h8001_ABCD, 1, 32'h0000_ABCD);
        test_done_hold();
        test_misalign();
        test_n64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
